// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP subsystem: image geometry, data widths and
// the host-memory responder state encoding. Also used by the LBP engine and
// its bench.
package lbp_pkg;

  localparam int unsigned IMG_W  = 128;
  localparam int unsigned IMG_H  = 128;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned PIX_W  = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lbp_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read
// port. A read and a write to the same address in the same cycle return the
// old contents (read-before-write). Array contents are never reset; only the
// read register is.
//   clk, reset     : clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr       : read enable/address; rdata holds while re=0
//   rdata          : registered read data
module lbp_sdp_ram #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side responder for the LBP engine's memory interfaces. Holds the
// grayscale source image (loaded by the host in raster order), serves engine
// reads with one-cycle latency, captures engine result writes and reports
// completion.
//   clk, reset                 : clock, asynchronous active-high reset
//   load_valid/load_data       : host image load stream; load_ready in LOAD
//   gray_ready                 : image resident, engine reads allowed
//   gray_req/gray_addr         : engine read; gray_data registered result
//   lbp_valid/lbp_addr/lbp_data: engine result write
//   finish                     : engine completion strobe
//   res_rd_addr/res_rd_data    : host result readback (1-cycle, any state)
//   wr_count                   : accepted result writes, saturating
//   done                       : finish observed
//   err_early                  : sticky, read request while image not ready
module lbp_host_mem #(
  parameter int unsigned ADDR_W = lbp_pkg::ADDR_W,
  parameter int unsigned PIX_W  = lbp_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [PIX_W-1:0]  load_data,
  output logic              load_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [PIX_W-1:0]  gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [PIX_W-1:0]  lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] res_rd_addr,
  output logic [PIX_W-1:0]  res_rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              done,
  output logic              err_early
);

  import lbp_pkg::*;

  state_t            state, state_next;
  logic [ADDR_W-1:0] load_ptr;
  logic              gray_we;
  logic              gray_re;
  logic              res_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    gray_ready = 1'b0;
    done       = 1'b0;
    gray_we    = 1'b0;
    gray_re    = 1'b0;
    res_we     = 1'b0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        gray_we    = load_valid;
        if (load_valid && (load_ptr == '1)) state_next = SERVE;
      end
      SERVE: begin
        gray_ready = 1'b1;
        gray_re    = gray_req;
        // A write coinciding with finish is still accepted.
        res_we     = lbp_valid;
        if (finish) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        load_ptr <= '0;
    else if (gray_we) load_ptr <= load_ptr + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wr_count <= '0;
    else if (res_we && wr_count != '1)  wr_count <= wr_count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       err_early <= 1'b0;
    else if (gray_req && !gray_ready) err_early <= 1'b1;
  end

  lbp_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) gray_mem (
    .clk   (clk),
    .reset (reset),
    .we    (gray_we),
    .waddr (load_ptr),
    .wdata (load_data),
    .re    (gray_re),
    .raddr (gray_addr),
    .rdata (gray_data)
  );

  lbp_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) result_mem (
    .clk   (clk),
    .reset (reset),
    .we    (res_we),
    .waddr (lbp_addr),
    .wdata (lbp_data),
    .re    (1'b1),
    .raddr (res_rd_addr),
    .rdata (res_rd_data)
  );

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: image load/reload, gray reads, early-read
// error flag, result writes/readback, read-before-write and finish handling.
module tb_lbp_host_mem;

  localparam int unsigned AW = 14;
  localparam int unsigned PW = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [PW-1:0] load_data;
  logic          load_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [PW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [PW-1:0] lbp_data;
  logic          finish;
  logic [AW-1:0] res_rd_addr;
  logic [PW-1:0] res_rd_data;
  logic [AW:0]   wr_count;
  logic          done;
  logic          err_early;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  lbp_host_mem #(
    .ADDR_W (AW),
    .PIX_W  (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .gray_ready  (gray_ready),
    .gray_req    (gray_req),
    .gray_addr   (gray_addr),
    .gray_data   (gray_data),
    .lbp_valid   (lbp_valid),
    .lbp_addr    (lbp_addr),
    .lbp_data    (lbp_data),
    .finish      (finish),
    .res_rd_addr (res_rd_addr),
    .res_rd_data (res_rd_data),
    .wr_count    (wr_count),
    .done        (done),
    .err_early   (err_early)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit invert);
    logic [31:0] v;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = i;
      load_valid = 1'b1;
      load_data  = invert ? ~v[7:0] : v[7:0];
      if (i == int'(DEPTH) - 1) check("gray_ready_before_last", {31'd0, gray_ready}, 32'd0);
      tick();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; load_valid = 1'b0; load_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; res_rd_addr = '0;
    #12;
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_gray_ready", {31'd0, gray_ready}, 32'd0);
    check("rst_gray_data",  {24'd0, gray_data},  32'd0);
    check("rst_res_rd",     {24'd0, res_rd_data}, 32'd0);
    check("rst_wr_count",   {17'd0, wr_count},   32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_err_early",  {31'd0, err_early},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Partial load of inverted data, then asynchronous reset mid-load.
    for (int i = 0; i < 1000; i++) begin
      v = i;
      load_valid = 1'b1;
      load_data  = ~v[7:0];
      tick();
    end
    load_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_gray_ready", {31'd0, gray_ready}, 32'd0);
    check("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    #3;
    reset = 1'b0;
    tick();

    // Read request during LOAD: no read, error flag set.
    gray_req = 1'b1; gray_addr = 14'd5;
    tick();
    gray_req = 1'b0;
    check("early_gray_data", {24'd0, gray_data}, 32'd0);
    check("early_err",       {31'd0, err_early}, 32'd1);

    // Full ramp load; reload must start from address 0.
    load_image(1'b0);
    check("gray_ready_after_last", {31'd0, gray_ready}, 32'd1);
    check("load_ready_serve",      {31'd0, load_ready}, 32'd0);
    check("err_sticky",            {31'd0, err_early},  32'd1);

    // Back-to-back reads.
    gray_req = 1'b1; gray_addr = 14'd0;
    tick();
    check("rd_addr0", {24'd0, gray_data}, 32'h00);
    gray_addr = 14'd129;
    tick();
    check("rd_addr129", {24'd0, gray_data}, 32'h81);
    gray_addr = 14'd16383;
    tick();
    check("rd_addr16383", {24'd0, gray_data}, 32'hFF);
    gray_addr = 14'd500;
    tick();
    check("rd_addr500_reload", {24'd0, gray_data}, 32'hF4);
    gray_req = 1'b0; gray_addr = 14'd7;
    load_valid = 1'b1; load_data = 8'h99;
    tick();
    tick();
    load_valid = 1'b0;
    check("rd_hold", {24'd0, gray_data}, 32'hF4);
    gray_req = 1'b1; gray_addr = 14'd0;
    tick();
    gray_req = 1'b0;
    check("load_ignored_serve", {24'd0, gray_data}, 32'h00);

    // Full set of result writes.
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = i;
      lbp_valid = 1'b1; lbp_addr = v[13:0]; lbp_data = v[7:0];
      tick();
    end
    lbp_valid = 1'b0;
    check("wr_count_full", {17'd0, wr_count}, 32'd16384);
    res_rd_addr = 14'd300;
    tick();
    check("readback_300", {24'd0, res_rd_data}, 32'h2C);

    // Read-before-write at address 20 (first set to 0x00).
    lbp_valid = 1'b1; lbp_addr = 14'd20; lbp_data = 8'h00;
    tick();
    res_rd_addr = 14'd20; lbp_data = 8'h77;
    tick();
    lbp_valid = 1'b0;
    check("rbw_old", {24'd0, res_rd_data}, 32'h00);
    tick();
    check("rbw_new", {24'd0, res_rd_data}, 32'h77);
    check("wr_count_rbw", {17'd0, wr_count}, 32'd16386);

    // Write together with finish.
    lbp_valid = 1'b1; lbp_addr = 14'd10; lbp_data = 8'h5A; finish = 1'b1;
    tick();
    finish = 1'b0;
    check("finish_wr_count", {17'd0, wr_count}, 32'd16387);
    check("finish_done",     {31'd0, done},     32'd1);
    check("done_gray_ready", {31'd0, gray_ready}, 32'd0);
    lbp_data = 8'h11; gray_req = 1'b1; gray_addr = 14'd129;
    tick();
    lbp_valid = 1'b0; gray_req = 1'b0;
    res_rd_addr = 14'd10;
    tick();
    check("done_readback10",  {24'd0, res_rd_data}, 32'h5A);
    check("done_wr_hold",     {17'd0, wr_count},    32'd16387);
    check("done_gray_hold",   {24'd0, gray_data},   32'h00);
    check("done_sticky",      {31'd0, done},        32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbp_host_mem.md
# lbp_host_mem

Host-side responder for the LBP engine's two memory interfaces. It holds the 128x128 grayscale source image and serves `gray_req`/`gray_addr` reads with registered `gray_data`. It captures every `lbp_valid` write into a result memory and reports completion when the engine raises `finish`. It sits opposite the LBP engine in the subsystem and replaces the behavioural memories used in the bench, so the engine can be exercised against synthesizable memory.

## Interface

Parameters:
- `ADDR_W`, 14, pixel address width; image depth is 2^ADDR_W.
- `PIX_W`, 8, gray and LBP data width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_valid` in 1: host pixel strobe during image load.
- `load_data` in PIX_W: host pixel, raster order from address 0.
- `load_ready` out 1: responder accepts load pixels.
- `gray_ready` out 1: image resident, reads allowed.
- `gray_req` in 1: engine read request.
- `gray_addr` in ADDR_W: engine read address.
- `gray_data` out PIX_W: registered read data.
- `lbp_valid` in 1: engine result write strobe.
- `lbp_addr` in ADDR_W: result address.
- `lbp_data` in PIX_W: result value.
- `finish` in 1: engine completion.
- `res_rd_addr` in ADDR_W: host result readback address.
- `res_rd_data` out PIX_W: registered result readback.
- `wr_count` out ADDR_W+1: accepted result writes, saturating at all-ones.
- `done` out 1: finish observed.
- `err_early` out 1: sticky; `gray_req` seen while `gray_ready`=0.

## Operation

- FSM states and transitions:
  - `LOAD` -> `SERVE` on the final (2^ADDR_W-th) accepted pixel.
  - `SERVE` -> `DONE` when `finish`=1 is sampled.
  - `DONE` is terminal until `reset`.
- `LOAD`:
  - `load_ready`=1.
  - Each cycle with `load_valid`=1 writes `load_data` to gray_mem[`load_ptr`], then `load_ptr`++.
  - `load_valid`=0 stalls without side effects.
- `SERVE`:
  - `gray_ready`=1, `load_ready`=0; `load_valid` is ignored.
  - `gray_req`=1 at edge t: `gray_data` = gray_mem[`gray_addr`] after edge t.
  - `gray_req`=0: `gray_data` holds its previous value.
  - `lbp_valid`=1: result_mem[`lbp_addr`] <= `lbp_data` and `wr_count`++ (saturating).
  - Rewriting the same address overwrites it and still counts.
- `DONE`:
  - `done`=1, `gray_ready`=0.
  - `lbp_valid` and `gray_req` are ignored.
  - `gray_data` and `wr_count` hold.
- `finish` and `lbp_valid` high in the same `SERVE` cycle: the write is accepted and counted, then the FSM enters `DONE`.
- `gray_req`=1 while in `LOAD`: no read occurs, `gray_data` holds, `err_early` is set. `err_early` clears only on reset.
- Result readback: `res_rd_data` = result_mem[`res_rd_addr`] one cycle later, in any state, independent of the engine ports.
- Reset values:
  - State `LOAD`, `load_ptr`=0, `load_ready`=1.
  - `gray_ready`=0, `gray_data`=0, `res_rd_data`=0.
  - `wr_count`=0, `done`=0, `err_early`=0.
  - Memory contents are not cleared.
- Reset mid-load or mid-serve: the state returns to `LOAD` asynchronously and the host must reload the full image.

## Timing

- Gray read latency is 1 cycle; one read per cycle at full throughput with no back-pressure.
- Result write is accepted in the `lbp_valid` cycle, and `wr_count` updates on the same edge.
- Write and readback of the same result address in the same cycle: `res_rd_data` returns the old value (read-before-write).
- `gray_ready` rises on the edge after the last load pixel is accepted.
- `done` rises on the edge after `finish` is sampled.

## Structure

- Shared package `lbp_pkg`:
  - `IMG_W`=128, `IMG_H`=128, `ADDR_W`=14, `PIX_W`=8.
  - State enum `LOAD`/`SERVE`/`DONE`.
  - This package is also used by the LBP engine and its bench.
- Sub-module `lbp_sdp_ram`: simple dual-port synchronous RAM with one write port, one registered read port, and read-before-write. It is instantiated twice, as gray_mem and result_mem.
- The top contains the FSM, `load_ptr`, `wr_count`, and the status flags.

## Test plan

- Load ramp pixel[i]=i[7:0]; read addresses 0, 129, 16383 back-to-back -> `gray_data` = 0x00, 0x81, 0xFF on the three following cycles; `gray_ready` rises exactly one edge after pixel 16383.
- `gray_req`=1 with addr 5 during `LOAD` -> `gray_data` stays 0, `err_early`=1 and stays 1 after load completes.
- 16384 `lbp_valid` writes with data=addr[7:0] -> `wr_count`=16384; readback of address 300 -> 0x2C one cycle later.
- `lbp_valid` (addr 10, data 0x5A) together with `finish` -> `wr_count` increments, `done`=1 next edge; a later write to address 10 is ignored and readback stays 0x5A.
- Reset asserted mid-load after 1000 pixels -> `load_ptr` back to 0, `gray_ready`=0; a full reload then serves the new data correctly.
- Same-cycle write 0x77 and readback at address 20 (old value 0x00) -> `res_rd_data`=0x00, then 0x77 on the next read.
